pump_driver: RTL and testbench

PUMP_DRIVER -- requirements
Module: pump_driver

---
 rtl/pump_driver.sv | 166 ++++++++++++++++
 tb/tb_pump_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pump_driver.sv
// Duplex pump driver: starts the armed pump after a delay and holds it for a minimum run.
// It fails over to the other pump on loss of flow and latches a fault if both pumps fail.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no demand, motors off, waiting for demand
// START | start delay running for the latched pump, motor still off
// RUN   | selected motor enabled, minimum-run and no-flow timers active
// FAULT | both pumps failed to produce flow; motors off until reset
module pump_driver #(
  parameter int unsigned START_DLY = 4,
  parameter int unsigned MIN_RUN   = 8,
  parameter int unsigned FLOW_TO   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic demand,
  input  logic use_pump,
  input  logic flow,
  output logic pump1_on,
  output logic pump2_on,
  output logic B1,
  output logic B2,
  output logic fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0] START_LAST = 8'(START_DLY - 1);
  localparam logic [7:0] MIN_RUN_C  = 8'(MIN_RUN);
  localparam logic [7:0] FLOW_LAST  = 8'(FLOW_TO - 1);

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       retry_q, retry_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] run_q, run_d;
  logic [7:0] nf_q, nf_d;
  logic       p1_q, p1_d;
  logic       p2_q, p2_d;
  logic       b1_q, b1_d;
  logic       b2_q, b2_d;
  logic       fault_q, fault_d;

  logic       stop_ok;
  logic       no_flow;

  // Normal stop is evaluated first so it wins over a coincident no-flow event.
  assign stop_ok = !demand && (run_q >= MIN_RUN_C);
  assign no_flow = !flow && (nf_q == FLOW_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    nf_d    = nf_q;
    p1_d    = 1'b0;
    p2_d    = 1'b0;
    b1_d    = b1_q;
    b2_d    = b2_q;
    fault_d = 1'b0;

    case (state_q)
      IDLE: begin
        retry_d = 1'b0;
        cnt_d   = 8'd0;
        run_d   = 8'd0;
        nf_d    = 8'd0;
        if (demand) begin
          sel_d   = use_pump;
          state_d = START;
        end
      end

      START: begin
        if (!demand) begin
          state_d = IDLE;
          retry_d = 1'b0;
          cnt_d   = 8'd0;
        end else if (cnt_q == START_LAST) begin
          state_d = RUN;
          run_d   = 8'd1;
          nf_d    = 8'd0;
          p1_d    = sel_q;
          p2_d    = !sel_q;
          b1_d    = sel_q;
          b2_d    = !sel_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RUN: begin
        if (stop_ok) begin
          state_d = IDLE;
          retry_d = 1'b0;
        end else if (no_flow) begin
          if (retry_q) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = START;
            retry_d = 1'b1;
            sel_d   = !sel_q;
            cnt_d   = 8'd0;
          end
        end else begin
          p1_d  = sel_q;
          p2_d  = !sel_q;
          run_d = (run_q >= MIN_RUN_C) ? run_q : run_q + 8'd1;
          nf_d  = flow ? 8'd0 : nf_q + 8'd1;
        end
      end

      FAULT: begin
        fault_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      retry_q <= 1'b0;
      cnt_q   <= 8'd0;
      run_q   <= 8'd0;
      nf_q    <= 8'd0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      b1_q    <= 1'b0;
      b2_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      nf_q    <= nf_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      fault_q <= fault_d;
    end
  end

  assign pump1_on = p1_q;
  assign pump2_on = p2_q;
  assign B1       = b1_q;
  assign B2       = b2_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_pump_driver.sv
// Scoreboard bench for pump_driver: a timestamp-based reference model predicts every cycle's outputs.
module tb_pump_driver;

  localparam int START_DLY = 4;
  localparam int MIN_RUN   = 8;
  localparam int FLOW_TO   = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic demand = 1'b0;
  logic use_pump = 1'b0;
  logic flow = 1'b0;
  logic pump1_on, pump2_on, B1, B2, fault;

  pump_driver #(.START_DLY(START_DLY), .MIN_RUN(MIN_RUN), .FLOW_TO(FLOW_TO)) dut (
    .clk(clk), .reset(reset), .demand(demand), .use_pump(use_pump), .flow(flow),
    .pump1_on(pump1_on), .pump2_on(pump2_on), .B1(B1), .B2(B2), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic p1;
    logic p2;
    logic b1;
    logic b2;
    logic flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  // Reference model: event timestamps instead of a state machine.
  int t = 0;
  int wait_from, run_from, last_wet, last_pump;
  bit tried, armed, faulted;

  function automatic void m_reset();
    wait_from = -1;
    run_from  = -1;
    last_wet  = 0;
    last_pump = 0;
    tried     = 1'b0;
    armed     = 1'b0;
    faulted   = 1'b0;
  endfunction

  function automatic void m_step(input bit d, input bit u, input bit f);
    t++;
    if (faulted) begin
    end else if (run_from >= 0) begin
      if (f) last_wet = t;
      if (!d && (t - run_from) >= MIN_RUN) begin
        run_from = -1;
      end else if (!f && (t - last_wet) >= FLOW_TO) begin
        run_from = -1;
        if (tried) faulted = 1'b1;
        else begin
          tried     = 1'b1;
          armed     = !armed;
          wait_from = t;
        end
      end
    end else if (wait_from >= 0) begin
      if (!d) wait_from = -1;
      else if ((t - wait_from) == START_DLY) begin
        run_from  = t;
        last_wet  = t;
        last_pump = armed ? 1 : 2;
        wait_from = -1;
      end
    end else if (d) begin
      armed     = u;
      wait_from = t;
      tried     = 1'b0;
    end
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    e.p1  = (run_from >= 0) && armed;
    e.p2  = (run_from >= 0) && !armed;
    e.b1  = (last_pump == 1);
    e.b2  = (last_pump == 2);
    e.flt = faulted;
    return e;
  endfunction

  // Called at a negedge: apply inputs, advance model at the next posedge, return at the following negedge.
  task automatic drive(input bit d, input bit u, input bit f);
    demand   = d;
    use_pump = u;
    flow     = f;
    @(posedge clk);
    m_step(d, u, f);
    exp_q.push_back(m_out());
    n_push++;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    n_chk++;
    if ({pump1_on, pump2_on, B1, B2, fault} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s: got p1=%b p2=%b B1=%b B2=%b fault=%b, required all 0",
               name, pump1_on, pump2_on, B1, B2, fault);
    end
  endtask

  // Asynchronous reset asserted between clock edges, held over one edge.
  task automatic reset_pulse(input bit d, input bit u, input bit f);
    demand   = d;
    use_pump = u;
    flow     = f;
    @(posedge clk);
    m_step(d, u, f);
    exp_q.push_back(m_out());
    n_push++;
    #3 reset = 1'b1;
    #1 check_all_zero("async_reset");
    m_reset();
    @(posedge clk);
    exp_q.push_back(m_out());
    n_push++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_pop++;
        n_chk++;
        if ({pump1_on, pump2_on, B1, B2, fault} !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got p1=%b p2=%b B1=%b B2=%b fault=%b, required p1=%b p2=%b B1=%b B2=%b fault=%b",
                   $time, pump1_on, pump2_on, B1, B2, fault, e.p1, e.p2, e.b1, e.b2, e.flt);
        end
        n_chk++;
        if (pump1_on && pump2_on) begin
          n_fail++;
          $display("FAIL exclusive @%0t: got both motors on, required at most one", $time);
        end
      end
    end
  end

  initial begin : stimulus
    bit d, u, f;
    m_reset();
    #2 check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Normal run on pump 1.
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)  drive(1'b0, 1'b1, 1'b1);
    // Short demand: no motor, B1/B2 unchanged.
    for (int i = 0; i < 2; i++)  drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)  drive(1'b0, 1'b0, 1'b1);
    // Minimum run on pump 2, demand drops 2 cycles after the motor starts.
    for (int i = 0; i < START_DLY + 2; i++) drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) drive(1'b0, 1'b1, 1'b1);
    // Failover from pump 1 to pump 2, then flow recovers.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b1);
    // Double failure, fault must persist with demand toggling.
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(i[0], 1'b0, 1'b1);
    reset_pulse(1'b1, 1'b0, 1'b0);
    // Reset in the middle of a pump 1 run.
    for (int i = 0; i < START_DLY + 3; i++) drive(1'b1, 1'b1, 1'b1);
    reset_pulse(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);

    // Randomized traffic with sticky demand and flow.
    d = 1'b0;
    f = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) d = !d;
      if ($urandom_range(0, 7) == 0)  f = !f;
      u = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) reset_pulse(d, u, f);
      else drive(d, u, f);
    end

    @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0 || n_pop != n_push) begin
      n_fail++;
      $display("FAIL drain: got %0d popped of %0d pushed, required all popped", n_pop, n_push);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
